z80fi_insn_capture: RTL

// - Upstream feeder of the z80fi instruction-spec modules and their checker.
// - Observes the core's per-T-state bus/cycle events and assembles one z80fi record per retired instruction:
//   - opcode bytes and length;
//   - register snapshots in/out;
//   - M-cycle types and T-cycle counts;
//   - memory writes and reads.
// - Presents each record with a 1-cycle z80fi_valid pulse; the record holds stable until the next pulse.

---
 rtl/z80fi_insn_capture_pkg.sv | 30 +++
 rtl/z80fi_mcycle_log.sv | 63 ++++++
 rtl/z80fi_insn_capture.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/z80fi_insn_capture_pkg.sv
// Shared z80fi encodings, capacities and record helper types for the
// instruction capture block and its M-cycle logger.
package z80fi_insn_capture_pkg;

  localparam logic [2:0] CYCLE_NONE   = 3'd0;
  localparam logic [2:0] CYCLE_M1     = 3'd1;
  localparam logic [2:0] CYCLE_MEM_RD = 3'd2;
  localparam logic [2:0] CYCLE_MEM_WR = 3'd3;
  localparam logic [2:0] CYCLE_IO_RD  = 3'd4;
  localparam logic [2:0] CYCLE_IO_WR  = 3'd5;
  localparam logic [2:0] CYCLE_INTA   = 3'd6;

  localparam int Z80FI_MAX_BYTES = 4;
  localparam int Z80FI_MAX_MCYC  = 6;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } cap_state_t;

  // First two accesses of one direction plus a saturating access count.
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic [15:0] addr2;
    logic [7:0]  data2;
    logic [1:0]  count;
  } bus_log_t;

endpackage

// File: rtl/z80fi_mcycle_log.sv
// Per-instruction M-cycle log: slot index, per-slot cycle type and
// saturating T-state count, with overflow once all slots are used.
module z80fi_mcycle_log
  import z80fi_insn_capture_pkg::*;
#(
  parameter int MAX_MCYC = Z80FI_MAX_MCYC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  open,
  input  logic                  active,
  input  logic                  mcycle_start,
  input  logic [2:0]            mcycle_type,
  input  logic                  tstate,
  output logic [MAX_MCYC*3-1:0] slot_type,
  output logic [MAX_MCYC*4-1:0] slot_tcycles,
  output logic                  overflow
);

  localparam int TCW   = MAX_MCYC * 4;
  localparam int IDX_W = (MAX_MCYC > 1) ? $clog2(MAX_MCYC) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(MAX_MCYC - 1);

  logic [IDX_W-1:0] cur;
  logic             drop;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_type    <= {MAX_MCYC{CYCLE_NONE}};
      slot_tcycles <= '0;
      cur          <= '0;
      drop         <= 1'b0;
      overflow     <= 1'b0;
    end else if (open) begin
      // A new instruction always lands in slot 0, even without mcycle_start.
      slot_type      <= {MAX_MCYC{CYCLE_NONE}};
      slot_type[2:0] <= mcycle_start ? mcycle_type : CYCLE_M1;
      slot_tcycles   <= TCW'(tstate);
      cur            <= '0;
      drop           <= 1'b0;
      overflow       <= 1'b0;
    end else if (active) begin
      if (mcycle_start) begin
        if (drop || cur == LAST) begin
          // Excess M-cycles and their T-states are discarded.
          drop     <= 1'b1;
          overflow <= 1'b1;
        end else begin
          cur                                  <= cur + 1'b1;
          slot_type[3*(int'(cur)+1) +: 3]      <= mcycle_type;
          slot_tcycles[4*(int'(cur)+1) +: 4]   <= tstate ? 4'd1 : 4'd0;
        end
      end else if (tstate && !drop) begin
        slot_tcycles[4*int'(cur) +: 4] <= sat_inc4(slot_tcycles[4*int'(cur) +: 4]);
      end
    end
  end

endmodule

// File: rtl/z80fi_insn_capture.sv
// Assembles one z80fi record per retired instruction from per-T-state core
// events; the record is published with a one-cycle z80fi_valid pulse.
module z80fi_insn_capture
  import z80fi_insn_capture_pkg::*;
#(
  parameter int REGS_W    = 208,
  parameter int MAX_BYTES = Z80FI_MAX_BYTES,
  parameter int MAX_MCYC  = Z80FI_MAX_MCYC
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_insn_start,
  input  logic [REGS_W-1:0]      cpu_regs,
  input  logic                   cpu_mcycle_start,
  input  logic [2:0]             cpu_mcycle_type,
  input  logic                   cpu_tstate,
  input  logic                   cpu_fetch,
  input  logic [7:0]             cpu_fetch_data,
  input  logic                   cpu_mem_wr,
  input  logic                   cpu_mem_rd,
  input  logic [15:0]            cpu_mem_addr,
  input  logic [7:0]             cpu_mem_data,
  output logic                   z80fi_valid,
  output logic [8*MAX_BYTES-1:0] z80fi_insn,
  output logic [2:0]             z80fi_insn_len,
  output logic [REGS_W-1:0]      z80fi_regs_in,
  output logic [REGS_W-1:0]      z80fi_regs_out,
  output logic [MAX_MCYC*3-1:0]  z80fi_mcycle_type,
  output logic [MAX_MCYC*4-1:0]  z80fi_tcycles,
  output logic [15:0]            z80fi_waddr,
  output logic [15:0]            z80fi_waddr2,
  output logic [7:0]             z80fi_wdata,
  output logic [7:0]             z80fi_wdata2,
  output logic [15:0]            z80fi_raddr,
  output logic [15:0]            z80fi_raddr2,
  output logic [7:0]             z80fi_rdata,
  output logic [7:0]             z80fi_rdata2,
  output logic [1:0]             z80fi_wr_count,
  output logic [1:0]             z80fi_rd_count,
  output logic                   z80fi_overflow
);

  localparam int INSN_W = 8 * MAX_BYTES;
  localparam logic [2:0] LEN_MAX = 3'(MAX_BYTES);

  cap_state_t              state;
  logic                    run;
  logic [REGS_W-1:0]       regs_acc;
  logic [INSN_W-1:0]       insn_acc;
  logic [2:0]              len_acc;
  bus_log_t                wr_acc;
  bus_log_t                rd_acc;
  logic                    ovf_acc;
  logic [MAX_MCYC*3-1:0]   log_types;
  logic [MAX_MCYC*4-1:0]   log_tcycles;
  logic                    log_ovf;

  assign run = (state == ST_RUN);

  // Keeps the first two accesses; the count saturates at 3.
  function automatic bus_log_t log_access(input bus_log_t l, input logic [15:0] a,
                                          input logic [7:0] d);
    bus_log_t r;
    r = l;
    if (l.count == 2'd0) begin
      r.addr = a;
      r.data = d;
    end else if (l.count == 2'd1) begin
      r.addr2 = a;
      r.data2 = d;
    end
    if (l.count != 2'd3) r.count = l.count + 2'd1;
    return r;
  endfunction

  z80fi_mcycle_log #(
    .MAX_MCYC(MAX_MCYC)
  ) u_mcycle_log (
    .clk         (clk),
    .reset       (reset),
    .open        (cpu_insn_start),
    .active      (run),
    .mcycle_start(cpu_mcycle_start),
    .mcycle_type (cpu_mcycle_type),
    .tstate      (cpu_tstate),
    .slot_type   (log_types),
    .slot_tcycles(log_tcycles),
    .overflow    (log_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_IDLE;
      regs_acc          <= '0;
      insn_acc          <= '0;
      len_acc           <= '0;
      wr_acc            <= '0;
      rd_acc            <= '0;
      ovf_acc           <= 1'b0;
      z80fi_valid       <= 1'b0;
      z80fi_insn        <= '0;
      z80fi_insn_len    <= '0;
      z80fi_regs_in     <= '0;
      z80fi_regs_out    <= '0;
      z80fi_mcycle_type <= {MAX_MCYC{CYCLE_NONE}};
      z80fi_tcycles     <= '0;
      z80fi_waddr       <= '0;
      z80fi_waddr2      <= '0;
      z80fi_wdata       <= '0;
      z80fi_wdata2      <= '0;
      z80fi_raddr       <= '0;
      z80fi_raddr2      <= '0;
      z80fi_rdata       <= '0;
      z80fi_rdata2      <= '0;
      z80fi_wr_count    <= '0;
      z80fi_rd_count    <= '0;
      z80fi_overflow    <= 1'b0;
    end else begin
      z80fi_valid <= 1'b0;
      if (cpu_insn_start) begin
        // Close the open record, then reopen with this cycle's events.
        if (state == ST_RUN) begin
          z80fi_valid       <= 1'b1;
          z80fi_insn        <= insn_acc;
          z80fi_insn_len    <= len_acc;
          z80fi_regs_in     <= regs_acc;
          z80fi_regs_out    <= cpu_regs;
          z80fi_mcycle_type <= log_types;
          z80fi_tcycles     <= log_tcycles;
          z80fi_waddr       <= wr_acc.addr;
          z80fi_wdata       <= wr_acc.data;
          z80fi_waddr2      <= wr_acc.addr2;
          z80fi_wdata2      <= wr_acc.data2;
          z80fi_wr_count    <= wr_acc.count;
          z80fi_raddr       <= rd_acc.addr;
          z80fi_rdata       <= rd_acc.data;
          z80fi_raddr2      <= rd_acc.addr2;
          z80fi_rdata2      <= rd_acc.data2;
          z80fi_rd_count    <= rd_acc.count;
          z80fi_overflow    <= ovf_acc | log_ovf;
        end
        state    <= ST_RUN;
        regs_acc <= cpu_regs;
        insn_acc <= cpu_fetch ? INSN_W'(cpu_fetch_data) : '0;
        len_acc  <= cpu_fetch ? 3'd1 : 3'd0;
        wr_acc   <= cpu_mem_wr ? log_access('0, cpu_mem_addr, cpu_mem_data) : '0;
        rd_acc   <= cpu_mem_rd ? log_access('0, cpu_mem_addr, cpu_mem_data) : '0;
        ovf_acc  <= 1'b0;
      end else if (state == ST_RUN) begin
        if (cpu_fetch) begin
          if (len_acc < LEN_MAX) begin
            insn_acc[8*int'(len_acc) +: 8] <= cpu_fetch_data;
            len_acc                        <= len_acc + 3'd1;
          end else begin
            ovf_acc <= 1'b1;
          end
        end
        if (cpu_mem_wr) begin
          wr_acc <= log_access(wr_acc, cpu_mem_addr, cpu_mem_data);
          if (wr_acc.count >= 2'd2) ovf_acc <= 1'b1;
        end
        if (cpu_mem_rd) begin
          rd_acc <= log_access(rd_acc, cpu_mem_addr, cpu_mem_data);
          if (rd_acc.count >= 2'd2) ovf_acc <= 1'b1;
        end
      end
    end
  end

endmodule
